// File: rtl/ntt_butterfly_ctrl_if.sv
// Port bundle between the NTT butterfly sequencer and its surroundings.
// The slave side is the sequencer; the master side starts runs and consumes
// the read/twiddle/write-back address streams.
interface ntt_butterfly_ctrl_if;
    logic        start_i;
    logic        mode_i;
    logic        inv_i;
    logic        busy_o;
    logic        done_o;
    logic        rd_en_o;
    logic [7:0]  rd_addr_a_o;
    logic [7:0]  rd_addr_b_o;
    logic [7:0]  tw_addr_o;
    logic        wr_en_o;
    logic [7:0]  wr_addr_a_o;
    logic [7:0]  wr_addr_b_o;
    logic [22:0] q_o;
    logic        sel_mul_o;
    logic        sel_butterfly_o;

    modport master (
        output start_i, mode_i, inv_i,
        input  busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o, q_o, sel_mul_o, sel_butterfly_o
    );

    modport slave (
        input  start_i, mode_i, inv_i,
        output busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o, q_o, sel_mul_o, sel_butterfly_o
    );
endinterface

// File: rtl/ntt_butterfly_ctrl.sv
// Sequencer for a single shared butterfly unit running a 256-point in-place
// forward (CT) or inverse (GS) NTT for Kyber (7 stages) or Dilithium (8).
// One butterfly is issued per cycle; write-back addresses are the read
// addresses delayed by the RAM read plus butterfly pipeline latency.
module ntt_butterfly_ctrl #(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    ntt_butterfly_ctrl_if.slave bus
);
    // Cycles between the last read of a stage and its last write-back.
    localparam int D  = RD_LAT + BF_LAT;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'((D > 0) ? D - 1 : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [22:0] Q_KYBER     = 23'd3329;
    localparam logic [22:0] Q_DILITHIUM = 23'd8380417;

    logic [1:0]    r_state;
    logic          r_mode;
    logic          r_inv;
    logic [2:0]    r_l;        // stage exponent, len = 2^r_l
    logic [6:0]    r_i;        // butterfly index within the stage
    logic [DW-1:0] r_dcnt;
    logic [22:0]   r_q;
    logic          r_sel_mul;
    logic          r_sel_bf;

    logic [2:0] w_lstop;
    logic       w_last_stage;
    logic [2:0] w_next_l;
    logic       w_rd_en;
    logic [7:0] w_len;
    logic [7:0] w_g;
    logic [7:0] w_o;
    logic [3:0] w_sh;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [8:0] w_tw9;
    logic [7:0] w_rd_a;
    logic [7:0] w_rd_b;
    logic [7:0] w_tw;

    // Dilithium goes one stage further (len = 1) than Kyber (len = 2).
    assign w_lstop      = r_mode ? 3'd0 : 3'd1;
    assign w_last_stage = r_inv ? (r_l == 3'd7) : (r_l == w_lstop);
    assign w_next_l     = r_inv ? (r_l + 3'd1) : (r_l - 3'd1);

    // Main sequencer: stage/index counters, drain counter and latched run settings.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_inv     <= 1'b0;
            r_l       <= 3'd0;
            r_i       <= 7'd0;
            r_dcnt    <= '0;
            r_q       <= 23'd0;
            r_sel_mul <= 1'b0;
            r_sel_bf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_mode    <= bus.mode_i;
                        r_inv     <= bus.inv_i;
                        r_q       <= bus.mode_i ? Q_DILITHIUM : Q_KYBER;
                        r_sel_mul <= bus.mode_i;
                        r_sel_bf  <= bus.inv_i;
                        r_l       <= bus.inv_i ? (bus.mode_i ? 3'd0 : 3'd1) : 3'd7;
                        r_i       <= 7'd0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_i <= r_i + 7'd1;
                    if (r_i == 7'd127) begin
                        if (D == 0) begin
                            if (w_last_stage) begin
                                r_state <= S_DONE;
                            end else begin
                                r_l <= w_next_l;
                            end
                        end else begin
                            r_dcnt  <= '0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == DCNT_LAST) begin
                        if (w_last_stage) begin
                            r_state <= S_DONE;
                        end else begin
                            r_l     <= w_next_l;
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Butterfly address generation: group g, offset o within the group.
    always_comb begin
        w_rd_en = (r_state == S_ISSUE);
        w_len   = 8'd1 << r_l;
        w_g     = {1'b0, r_i} >> r_l;
        w_o     = {1'b0, r_i} & (w_len - 8'd1);
        w_sh    = {1'b0, r_l} + 4'd1;
        w_a     = (w_g << w_sh) + w_o;
        w_b     = w_a + w_len;
        // Forward walks twiddles upward from 2^(7-L); inverse walks them
        // downward from 2^(8-L)-1, which needs a 9th bit when L = 0.
        if (r_inv) begin
            w_tw9 = (9'd256 >> r_l) - 9'd1 - {1'b0, w_g};
        end else begin
            w_tw9 = (9'd128 >> r_l) + {1'b0, w_g};
        end
        w_rd_a = w_rd_en ? w_a : 8'd0;
        w_rd_b = w_rd_en ? w_b : 8'd0;
        w_tw   = w_rd_en ? w_tw9[7:0] : 8'd0;
    end

    assign bus.rd_en_o         = w_rd_en;
    assign bus.rd_addr_a_o     = w_rd_a;
    assign bus.rd_addr_b_o     = w_rd_b;
    assign bus.tw_addr_o       = w_tw;
    assign bus.busy_o          = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign bus.done_o          = (r_state == S_DONE);
    assign bus.q_o             = r_q;
    assign bus.sel_mul_o       = r_sel_mul;
    assign bus.sel_butterfly_o = r_sel_bf;

    // Write-back pipeline: read strobe/addresses delayed by exactly D cycles.
    generate
        if (D == 0) begin : g_nopipe
            assign bus.wr_en_o     = w_rd_en;
            assign bus.wr_addr_a_o = w_rd_a;
            assign bus.wr_addr_b_o = w_rd_b;
        end else begin : g_pipe
            logic       r_pen [D];
            logic [7:0] r_pa  [D];
            logic [7:0] r_pb  [D];

            for (genvar gi = 0; gi < D; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    // First stage captures the live read strobe and addresses.
                    always_ff @(posedge clk_i or posedge rst_i) begin
                        if (rst_i) begin
                            r_pen[0] <= 1'b0;
                            r_pa[0]  <= 8'd0;
                            r_pb[0]  <= 8'd0;
                        end else begin
                            r_pen[0] <= w_rd_en;
                            r_pa[0]  <= w_rd_a;
                            r_pb[0]  <= w_rd_b;
                        end
                    end
                end else begin : g_next
                    // Later stages shift the previous stage along.
                    always_ff @(posedge clk_i or posedge rst_i) begin
                        if (rst_i) begin
                            r_pen[gi] <= 1'b0;
                            r_pa[gi]  <= 8'd0;
                            r_pb[gi]  <= 8'd0;
                        end else begin
                            r_pen[gi] <= r_pen[gi-1];
                            r_pa[gi]  <= r_pa[gi-1];
                            r_pb[gi]  <= r_pb[gi-1];
                        end
                    end
                end
            end

            assign bus.wr_en_o     = r_pen[D-1];
            assign bus.wr_addr_a_o = r_pa[D-1];
            assign bus.wr_addr_b_o = r_pb[D-1];
        end
    endgenerate
endmodule

// File: tb/tb_ntt_butterfly_ctrl.sv
// Randomized self-checking bench for ntt_butterfly_ctrl. A cycle-indexed
// schedule of expected outputs is built from the textbook NTT loop nest
// (groups, offsets, running twiddle index) and compared every cycle.
module tb_ntt_butterfly_ctrl;
    localparam int RD_LAT = 1;
    localparam int BF_LAT = 1;
    localparam int D      = RD_LAT + BF_LAT;
    localparam int MAXC   = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_butterfly_ctrl_if bus();

    ntt_butterfly_ctrl #(.RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int e_rd_en [MAXC];
    int e_ra    [MAXC];
    int e_rb    [MAXC];
    int e_tw    [MAXC];
    int e_wr_en [MAXC];
    int e_wa    [MAXC];
    int e_wb    [MAXC];
    int e_busy  [MAXC];
    int e_done  [MAXC];
    int done_cyc;
    int n_stages;
    int e_q, e_mul, e_bf;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected schedule from the reference NTT loop nest.
    function automatic void build_model(input int mode, input int inv);
        int lstop, k, cyc, L, len;
        for (int c = 0; c < MAXC; c++) begin
            e_rd_en[c] = 0; e_ra[c] = 0; e_rb[c] = 0; e_tw[c] = 0;
            e_wr_en[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_busy[c] = 0; e_done[c] = 0;
        end
        lstop    = mode ? 0 : 1;
        n_stages = 8 - lstop;
        k        = inv ? (1 << (8 - lstop)) - 1 : 1;
        cyc      = 1;
        for (int s = 0; s < n_stages; s++) begin
            L   = inv ? lstop + s : 7 - s;
            len = 1 << L;
            for (int g = 0; g < 256 / (2 * len); g++) begin
                for (int o = 0; o < len; o++) begin
                    e_rd_en[cyc]   = 1;
                    e_ra[cyc]      = g * 2 * len + o;
                    e_rb[cyc]      = g * 2 * len + o + len;
                    e_tw[cyc]      = k;
                    e_wr_en[cyc+D] = 1;
                    e_wa[cyc+D]    = e_ra[cyc];
                    e_wb[cyc+D]    = e_rb[cyc];
                    e_busy[cyc]    = 1;
                    cyc++;
                end
                k = inv ? k - 1 : k + 1;
            end
            for (int d = 0; d < D; d++) begin
                e_busy[cyc] = 1;
                cyc++;
            end
        end
        done_cyc = cyc;
        e_done[cyc] = 1;
        e_q   = mode ? 8380417 : 3329;
        e_mul = mode;
        e_bf  = inv;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, " rd_en"}, int'(bus.rd_en_o), 0);
        check_eq({tag, " rd_a"}, int'(bus.rd_addr_a_o), 0);
        check_eq({tag, " rd_b"}, int'(bus.rd_addr_b_o), 0);
        check_eq({tag, " tw"}, int'(bus.tw_addr_o), 0);
        check_eq({tag, " wr_en"}, int'(bus.wr_en_o), 0);
        check_eq({tag, " wr_a"}, int'(bus.wr_addr_a_o), 0);
        check_eq({tag, " wr_b"}, int'(bus.wr_addr_b_o), 0);
        check_eq({tag, " busy"}, int'(bus.busy_o), 0);
        check_eq({tag, " done"}, int'(bus.done_o), 0);
        check_eq({tag, " q"}, int'(bus.q_o), 0);
        check_eq({tag, " sel_mul"}, int'(bus.sel_mul_o), 0);
        check_eq({tag, " sel_bf"}, int'(bus.sel_butterfly_o), 0);
    endtask

    // One run: start, compare every cycle against the schedule, optionally
    // disturb inputs mid-run, start during DONE, or reset at cycle rst_cyc.
    task automatic run_one(input int mode, input int inv, input int junk,
                           input int rst_cyc, input int start_in_done);
        int obs_reads, obs_done;
        string t;
        build_model(mode, inv);
        $display("[TB] run mode=%0d inv=%0d junk=%0d rst_cyc=%0d start_in_done=%0d",
                 mode, inv, junk, rst_cyc, start_in_done);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = mode[0];
        bus.inv_i   = inv[0];
        obs_reads = 0;
        obs_done  = -1;
        for (int c = 1; c <= done_cyc + 2; c++) begin
            @(negedge clk);
            t = $sformatf("m%0d i%0d c%0d", mode, inv, c);
            check_eq({t, " rd_en"}, int'(bus.rd_en_o), e_rd_en[c]);
            if (e_rd_en[c] != 0) begin
                check_eq({t, " rd_a"}, int'(bus.rd_addr_a_o), e_ra[c]);
                check_eq({t, " rd_b"}, int'(bus.rd_addr_b_o), e_rb[c]);
                check_eq({t, " tw"}, int'(bus.tw_addr_o), e_tw[c]);
            end
            check_eq({t, " wr_en"}, int'(bus.wr_en_o), e_wr_en[c]);
            if (e_wr_en[c] != 0) begin
                check_eq({t, " wr_a"}, int'(bus.wr_addr_a_o), e_wa[c]);
                check_eq({t, " wr_b"}, int'(bus.wr_addr_b_o), e_wb[c]);
            end
            check_eq({t, " busy"}, int'(bus.busy_o), e_busy[c]);
            check_eq({t, " done"}, int'(bus.done_o), e_done[c]);
            check_eq({t, " q"}, int'(bus.q_o), e_q);
            check_eq({t, " sel_mul"}, int'(bus.sel_mul_o), e_mul);
            check_eq({t, " sel_bf"}, int'(bus.sel_butterfly_o), e_bf);
            if (bus.rd_en_o) obs_reads++;
            if (bus.done_o) obs_done = c;

            if (c == rst_cyc) begin
                rst = 1'b1;
                #1;
                check_all_zero($sformatf("rst@c%0d", c));
                repeat (3) begin
                    @(negedge clk);
                    check_eq("rst hold done", int'(bus.done_o), 0);
                    check_eq("rst hold wr_en", int'(bus.wr_en_o), 0);
                    check_eq("rst hold busy", int'(bus.busy_o), 0);
                end
                rst = 1'b0;
                bus.start_i = 1'b0;
                repeat (D + 2) begin
                    @(negedge clk);
                    check_eq("post-rst done", int'(bus.done_o), 0);
                    check_eq("post-rst wr_en", int'(bus.wr_en_o), 0);
                    check_eq("post-rst rd_en", int'(bus.rd_en_o), 0);
                end
                return;
            end

            bus.start_i = 1'b0;
            if (junk != 0) begin
                bus.mode_i = 1'($urandom);
                bus.inv_i  = 1'($urandom);
                if (c < done_cyc && (c == 300 || $urandom_range(0, 15) == 0))
                    bus.start_i = 1'b1;
            end
            if (start_in_done != 0 && c == done_cyc) bus.start_i = 1'b1;
        end
        bus.start_i = 1'b0;
        check_eq($sformatf("m%0d i%0d total reads", mode, inv), obs_reads, n_stages * 128);
        check_eq($sformatf("m%0d i%0d done cycle", mode, inv), obs_done,
                 1 + n_stages * (128 + D));
    endtask

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
        bus.inv_i   = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        check_all_zero("reset held");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle after reset");

        run_one(0, 0, 0, 0, 1);   // Kyber forward, start during DONE ignored
        run_one(1, 1, 0, 0, 0);   // Dilithium inverse
        run_one(0, 1, 0, 0, 0);   // Kyber inverse
        run_one(0, 0, 1, 0, 0);   // mid-run start pulses and mode/inv toggles
        run_one(0, 0, 0, 500, 0); // asynchronous reset at cycle 500
        run_one(0, 0, 0, 0, 0);   // clean run after reset
        repeat (4) begin
            run_one(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1, 0,
                    int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
